// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: ID pipeline register, operand forwarding, load-use and long-op interlocks.
// Latency: one cycle from input handshake to out_valid when no hazard; operands resolved combinationally.
// Backpressure: holds the instruction while a hazard is pending or EXE refuses; in_allowin drops accordingly.
// Optional: define ID_PERF_CNT_EN to add the 32-bit stall_cycles counter output.
module id_operand_unit #(
    parameter int XLEN      = 32,
    parameter int NFWD      = 3,
    parameter int PAYLOAD_W = 168
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_allowin,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic                   in_rs1_use,
    input  logic                   in_rs2_use,
    input  logic [4:0]             in_rd,
    input  logic                   in_rd_we,
    input  logic                   in_long,
    input  logic                   flush,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [XLEN-1:0]        rf_rdata1,
    input  logic [XLEN-1:0]        rf_rdata2,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [5*NFWD-1:0]      fwd_dest,
    input  logic [XLEN*NFWD-1:0]   fwd_data,
    input  logic [NFWD-1:0]        fwd_ready,
    input  logic                   sb_clr_valid,
    input  logic [4:0]             sb_clr_addr,
`ifdef ID_PERF_CNT_EN
    output logic [31:0]            stall_cycles,
`endif
    output logic                   out_valid,
    input  logic                   out_allowin,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic [XLEN-1:0]        out_rs1_val,
    output logic [XLEN-1:0]        out_rs2_val,
    output logic [4:0]             out_rd,
    output logic                   out_rd_we,
    output logic                   out_long
);

    // Stage register contents
    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [4:0]           rs1_q, rs2_q, rd_q;
    logic                 rs1_use_q, rs2_use_q, rd_we_q, long_q;

    // Pending long-latency destinations; bit 0 never set
    logic [31:0]          sb_q, sb_d;

    logic [XLEN:0]        res1, res2;
    logic                 src1_blk, src2_blk, waw_blk, ready_go;
    logic                 load, issue;

    // Returns {ready, value}: r0 reads zero, youngest matching producer wins, else regfile.
    function automatic logic [XLEN:0] resolve(
        input logic [4:0]           idx,
        input logic [XLEN-1:0]      rf_val,
        input logic [NFWD-1:0]      we,
        input logic [5*NFWD-1:0]    dest,
        input logic [XLEN*NFWD-1:0] data,
        input logic [NFWD-1:0]      rdy
    );
        logic [XLEN:0] r;
        r = {1'b1, rf_val};
        // Scan oldest to youngest so the lowest index overrides
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (we[i] && (dest[5*i +: 5] == idx)) begin
                r = {rdy[i], data[XLEN*i +: XLEN]};
            end
        end
        if (idx == 5'd0) begin
            r = {1'b1, {XLEN{1'b0}}};
        end
        return r;
    endfunction

    assign rf_raddr1 = rs1_q;
    assign rf_raddr2 = rs2_q;

    // Operand resolution and hazard detection on the held instruction
    always_comb begin
        res1     = resolve(rs1_q, rf_rdata1, fwd_we, fwd_dest, fwd_data, fwd_ready);
        res2     = resolve(rs2_q, rf_rdata2, fwd_we, fwd_dest, fwd_data, fwd_ready);
        src1_blk = rs1_use_q & (~res1[XLEN] | sb_q[rs1_q]);
        src2_blk = rs2_use_q & (~res2[XLEN] | sb_q[rs2_q]);
        waw_blk  = rd_we_q & (rd_q != 5'd0) & sb_q[rd_q];
        ready_go = ~(src1_blk | src2_blk | waw_blk);
    end

    assign out_valid   = valid_q & ready_go & ~flush;
    assign in_allowin  = ~valid_q | (ready_go & out_allowin);
    assign issue       = out_valid & out_allowin;
    assign load        = in_valid & in_allowin & ~flush;

    assign out_payload = payload_q;
    assign out_rs1_val = res1[XLEN-1:0];
    assign out_rs2_val = res2[XLEN-1:0];
    assign out_rd      = rd_q;
    assign out_rd_we   = rd_we_q;
    assign out_long    = long_q;

    // Next valid: flush kills the stage and any instruction offered alongside it
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_allowin) begin
            valid_d = in_valid;
        end
    end

    // Scoreboard next state: clear first so a same-cycle set on the same register wins
    always_comb begin
        sb_d = sb_q;
        if (sb_clr_valid) begin
            sb_d[sb_clr_addr] = 1'b0;
        end
        if (issue && long_q && rd_we_q && (rd_q != 5'd0)) begin
            sb_d[rd_q] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            sb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            sb_q    <= sb_d;
        end
    end

    // Instruction fields captured on the input handshake; no reset needed
    always_ff @(posedge clk) begin
        if (load) begin
            payload_q <= in_payload;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            rs1_use_q <= in_rs1_use;
            rs2_use_q <= in_rs2_use;
            rd_q      <= in_rd;
            rd_we_q   <= in_rd_we;
            long_q    <= in_long;
        end
    end

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles a valid instruction is held by a hazard (flushed cycles excluded)
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (valid_q && !ready_go && !flush) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_operand_unit.sv
// Directed bench for id_operand_unit with an instruction-level reference model.
// Inputs change 1 time unit after each rising edge; outputs checked at the falling edge.
// Model state advances on the rising edge from the same inputs the DUT samples.
module tb_id_operand_unit;
    localparam int XLEN = 32;
    localparam int NFWD = 3;
    localparam int PW   = 168;

    logic                 clk, reset;
    logic                 in_valid, in_allowin;
    logic [PW-1:0]        in_payload;
    logic [4:0]           in_rs1, in_rs2, in_rd;
    logic                 in_rs1_use, in_rs2_use, in_rd_we, in_long, flush;
    logic [4:0]           rf_raddr1, rf_raddr2;
    logic [XLEN-1:0]      rf_rdata1, rf_rdata2;
    logic [NFWD-1:0]      fwd_we, fwd_ready;
    logic [5*NFWD-1:0]    fwd_dest;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic                 sb_clr_valid;
    logic [4:0]           sb_clr_addr;
    logic                 out_valid, out_allowin;
    logic [PW-1:0]        out_payload;
    logic [XLEN-1:0]      out_rs1_val, out_rs2_val;
    logic [4:0]           out_rd;
    logic                 out_rd_we, out_long;
`ifdef ID_PERF_CNT_EN
    logic [31:0]          stall_cycles;
`endif

    logic [XLEN-1:0] regs [32];
    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    id_operand_unit #(.XLEN(XLEN), .NFWD(NFWD), .PAYLOAD_W(PW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_payload(in_payload),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_long(in_long), .flush(flush),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
        .sb_clr_valid(sb_clr_valid), .sb_clr_addr(sb_clr_addr),
`ifdef ID_PERF_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .out_valid(out_valid), .out_allowin(out_allowin), .out_payload(out_payload),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_long(out_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic lit(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one held instruction, a per-register pending flag, a stall tally
    typedef struct {
        logic [PW-1:0] pl;
        logic [4:0]    rs1, rs2, rd;
        logic          u1, u2, we, lng;
    } ins_t;

    ins_t        m_ins;
    bit          m_valid = 1'b0;
    bit          m_sb [32];
    int unsigned m_stall = 0;

    function automatic bit blocked(input logic [4:0] idx, input logic u);
        if (!u || idx == 5'd0) return 1'b0;
        if (m_sb[idx]) return 1'b1;
        for (int i = 0; i < NFWD; i++)
            if (fwd_we[i] && fwd_dest[5*i +: 5] == idx) return !fwd_ready[i];
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] value_of(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
        for (int i = 0; i < NFWD; i++)
            if (fwd_we[i] && fwd_dest[5*i +: 5] == idx) return fwd_data[XLEN*i +: XLEN];
        return regs[idx];
    endfunction

    function automatic bit m_stalled();
        return m_valid && (blocked(m_ins.rs1, m_ins.u1) || blocked(m_ins.rs2, m_ins.u2) ||
                           (m_ins.we && m_ins.rd != 5'd0 && m_sb[m_ins.rd]));
    endfunction

    // Model update on the rising edge
    initial begin
        for (int r = 0; r < 32; r++) m_sb[r] = 1'b0;
        forever begin
            bit st, ovld, allow;
            @(posedge clk);
            if (reset) begin
                m_valid = 1'b0;
                m_stall = 0;
                for (int r = 0; r < 32; r++) m_sb[r] = 1'b0;
            end else begin
                st    = m_stalled();
                ovld  = m_valid && !st && !flush;
                allow = !m_valid || (!st && out_allowin);
                if (m_valid && st && !flush) m_stall++;
                if (sb_clr_valid) m_sb[sb_clr_addr] = 1'b0;
                if (ovld && out_allowin && m_ins.lng && m_ins.we && m_ins.rd != 5'd0)
                    m_sb[m_ins.rd] = 1'b1;
                if (flush) m_valid = 1'b0;
                else if (allow) begin
                    m_valid = in_valid;
                    if (in_valid) begin
                        m_ins.pl  = in_payload;
                        m_ins.rs1 = in_rs1;     m_ins.rs2 = in_rs2;   m_ins.rd  = in_rd;
                        m_ins.u1  = in_rs1_use; m_ins.u2  = in_rs2_use;
                        m_ins.we  = in_rd_we;   m_ins.lng = in_long;
                    end
                end
            end
        end
    end

    // Compare DUT against the model every falling edge
    initial begin
        forever begin
            bit st, ovld, allow;
            @(negedge clk);
            if (chk_en) begin
                st    = m_stalled();
                ovld  = m_valid && !st && !flush;
                allow = !m_valid || (!st && out_allowin);
                lit("out_valid", out_valid, ovld);
                lit("in_allowin", in_allowin, allow);
                if (m_valid) begin
                    lit("rf_raddr1", rf_raddr1, m_ins.rs1);
                    lit("rf_raddr2", rf_raddr2, m_ins.rs2);
                end
                if (ovld) begin
                    lit("out_payload", out_payload, m_ins.pl);
                    lit("out_rs1_val", out_rs1_val, value_of(m_ins.rs1));
                    lit("out_rs2_val", out_rs2_val, value_of(m_ins.rs2));
                    lit("out_rd", out_rd, m_ins.rd);
                    lit("out_rd_we", out_rd_we, m_ins.we);
                    lit("out_long", out_long, m_ins.lng);
                end
`ifdef ID_PERF_CNT_EN
                lit("stall_cycles", stall_cycles, m_stall);
`endif
            end
        end
    end

    function automatic logic [PW-1:0] mk_pl(input logic [31:0] tag);
        logic [PW-1:0] p;
        p = '0;
        p[31:0]     = tag;
        p[PW-1 -: 32] = ~tag;
        return p;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] tag, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                           input logic we, input logic lng);
        in_valid   = 1'b1;
        in_payload = mk_pl(tag);
        in_rs1 = rs1; in_rs1_use = u1;
        in_rs2 = rs2; in_rs2_use = u2;
        in_rd  = rd;  in_rd_we   = we; in_long = lng;
    endtask

    task automatic set_fwd(input int i, input logic we, input logic [4:0] d,
                           input logic [31:0] data, input logic rdy);
        fwd_we[i]            = we;
        fwd_dest[5*i +: 5]   = d;
        fwd_data[XLEN*i +: XLEN] = data;
        fwd_ready[i]         = rdy;
    endtask

    task automatic clr_fwd();
        fwd_we = '0; fwd_dest = '0; fwd_data = '0; fwd_ready = '1;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h1000_0000 + r;
        reset = 1'b1; in_valid = 1'b0; in_payload = '0;
        in_rs1 = '0; in_rs2 = '0; in_rs1_use = 1'b0; in_rs2_use = 1'b0;
        in_rd = '0; in_rd_we = 1'b0; in_long = 1'b0; flush = 1'b0;
        sb_clr_valid = 1'b0; sb_clr_addr = '0; out_allowin = 1'b1;
        clr_fwd();
        cyc(); cyc();
        reset = 1'b0; chk_en = 1'b1;
        #1;
        lit("rst_out_valid", out_valid, 0);
        lit("rst_in_allowin", in_allowin, 1);

        // Dependent ALU op forwarded from EXE
        present(32'h1, 5'd3, 1, 5'd4, 1, 5'd6, 1, 0);
        cyc(); in_valid = 1'b0;
        set_fwd(0, 1, 5'd3, 32'hAAAA_0003, 1);
        #1;
        lit("alu_fwd_valid", out_valid, 1);
        lit("alu_fwd_rs1", out_rs1_val, 32'hAAAA_0003);
        lit("alu_fwd_rs2", out_rs2_val, 32'h1000_0004);
        cyc(); clr_fwd();

        // Load-use: one stall, then value from MEM
        present(32'h2, 5'd5, 1, 5'd0, 0, 5'd8, 1, 0);
        cyc(); in_valid = 1'b0;
        set_fwd(0, 1, 5'd5, 32'hDEAD_BEEF, 0);
        #1;
        lit("ld_use_stall", out_valid, 0);
        cyc(); clr_fwd();
        set_fwd(1, 1, 5'd5, 32'h5555_0005, 1);
        #1;
        lit("ld_use_go", out_valid, 1);
        lit("ld_use_rs1", out_rs1_val, 32'h5555_0005);
`ifdef ID_PERF_CNT_EN
        lit("ld_use_cnt", stall_cycles, 1);
`endif
        cyc(); clr_fwd();

        // Producer priority and r0 immunity
        present(32'h3, 5'd0, 1, 5'd7, 1, 5'd0, 1, 0);
        cyc(); in_valid = 1'b0;
        set_fwd(0, 1, 5'd0, 32'hFFFF_FFFF, 0);
        set_fwd(1, 1, 5'd7, 32'h11, 1);
        set_fwd(2, 1, 5'd7, 32'h22, 1);
        #1;
        lit("r0_no_stall", out_valid, 1);
        lit("r0_zero", out_rs1_val, 0);
        lit("prio_rs2", out_rs2_val, 32'h11);
        cyc(); clr_fwd();

        // Long op to r9, dependent reader waits for the scoreboard clear
        present(32'h4, 5'd1, 1, 5'd2, 1, 5'd9, 1, 1);
        cyc();
        present(32'h5, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0);
        cyc(); in_valid = 1'b0;
        #1;
        lit("sb_stall", out_valid, 0);
        cyc();
        sb_clr_valid = 1'b1; sb_clr_addr = 5'd9;
        #1;
        lit("sb_clr_cycle", out_valid, 0);
        cyc(); sb_clr_valid = 1'b0;
        #1;
        lit("sb_release", out_valid, 1);
        lit("sb_release_rs1", out_rs1_val, 32'h1000_0009);
        // Second long op to r9, issued while a clear of r9 arrives: set must win
        present(32'h6, 5'd1, 0, 5'd2, 0, 5'd9, 1, 1);
        cyc();
        sb_clr_valid = 1'b1; sb_clr_addr = 5'd9;
        present(32'h7, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
        cyc(); sb_clr_valid = 1'b0; in_valid = 1'b0;
        #1;
        lit("waw_stall", out_valid, 0);
        cyc();
        sb_clr_valid = 1'b1; sb_clr_addr = 5'd9;
        cyc(); sb_clr_valid = 1'b0;
        #1;
        lit("waw_release", out_valid, 1);
        cyc();

        // Flush: stalled instruction killed, then an offered instruction dropped
        present(32'h8, 5'd0, 0, 5'd0, 0, 5'd20, 1, 1);
        cyc();
        present(32'h9, 5'd20, 1, 5'd0, 0, 5'd11, 1, 0);
        cyc(); in_valid = 1'b0;
        flush = 1'b1;
        cyc(); flush = 1'b0;
        #1;
        lit("flush_kill", out_valid, 0);
        present(32'hA, 5'd1, 1, 5'd0, 0, 5'd12, 1, 0);
        flush = 1'b1;
        cyc(); flush = 1'b0; in_valid = 1'b0;
        #1;
        lit("flush_drop", out_valid, 0);
        lit("flush_allowin", in_allowin, 1);
        present(32'hB, 5'd20, 1, 5'd0, 0, 5'd13, 1, 0);
        cyc(); in_valid = 1'b0;
        #1;
        lit("flush_sb_kept", out_valid, 0);

        // Reset while stalled clears stage and scoreboard
        reset = 1'b1;
        cyc(); reset = 1'b0;
        #1;
        lit("rst_mid_valid", out_valid, 0);
        lit("rst_mid_allowin", in_allowin, 1);
        present(32'hC, 5'd20, 1, 5'd0, 0, 5'd14, 1, 0);
        cyc(); in_valid = 1'b0;
        #1;
        lit("rst_sb_cleared", out_valid, 1);
`ifdef ID_PERF_CNT_EN
        lit("rst_cnt", stall_cycles, 0);
`endif
        cyc();

        // EXE backpressure holds the stage
        present(32'hD, 5'd2, 1, 5'd0, 0, 5'd15, 1, 0);
        cyc();
        out_allowin = 1'b0;
        present(32'hE, 5'd3, 1, 5'd0, 0, 5'd16, 1, 0);
        #1;
        lit("bp_allowin", in_allowin, 0);
        lit("bp_valid", out_valid, 1);
        cyc(); out_allowin = 1'b1;
        #1;
        lit("bp_held_payload", out_payload[31:0], 32'hD);
        cyc(); in_valid = 1'b0;
        #1;
        lit("bp_next_payload", out_payload[31:0], 32'hE);
        cyc(); cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
